// File: rtl/div4b_seq.sv
// Sequential restoring divider: one quotient bit per clock, results held until the next accepted start.
// Define DIV4_SIGNED_EN for two's-complement operands (adds a FIX cycle and the overflow flag).
module div4b_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

`ifdef DIV4_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    // Handshake: start is sampled on every rising edge but only accepted in IDLE or DONE
    // (busy=0); done is high for exactly the one cycle spent in DONE.
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        ZDIV,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] q_reg;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return (SIGNED_EN && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN) || (state == FIX) || (state == ZDIV);
    assign done   = (state == DONE);

    // The restored partial remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        p_shift = {p_reg, a_reg[WIDTH-1]};
        trial   = p_shift - {1'b0, b_reg};
        p_next  = trial[WIDTH] ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next  = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? ZDIV : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    state_nxt = SIGNED_EN ? FIX : DONE;
                end
            end
            FIX:     state_nxt = DONE;
            ZDIV:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            dvd_reg     <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= '0;
            a_reg       <= mag(dividend);
            b_reg       <= mag(divisor);
            dvd_reg     <= dividend;
            p_reg       <= '0;
            q_reg       <= '0;
            neg_q       <= SIGNED_EN && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= SIGNED_EN && dividend[WIDTH-1];
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    count <= count + 1'b1;
                    a_reg <= {a_reg[WIDTH-2:0], 1'b0};
                    p_reg <= p_next;
                    q_reg <= q_next;
                    if ((count == LAST) && !SIGNED_EN) begin
                        quotient  <= q_next;
                        remainder <= p_next;
                    end
                end
                FIX: begin
                    // Most-negative / -1 lands here as magnitude 2^(WIDTH-1) with no negation.
                    quotient  <= neg_q ? -q_reg : q_reg;
                    remainder <= neg_r ? -p_reg : p_reg;
                end
                ZDIV: begin
                    quotient    <= '1;
                    remainder   <= dvd_reg;
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV4_SIGNED_EN
    logic ovf_case;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_case <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            ovf_case <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            overflow <= 1'b0;
        end else if (state == FIX) begin
            overflow <= ovf_case;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_div4b_seq.sv
// Directed bench for div4b_seq: vector table, exhaustive unsigned sweep and multi-cycle corner sequences.
// Build with DIV4_SIGNED_EN defined to exercise the signed configuration.
module tb_div4b_seq;

    localparam int W = 4;
`ifdef DIV4_SIGNED_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int           checks = 0;
    int           failures = 0;
    logic [9:0]   exp_q[$];   // {ovf, dbz, q, r}
    vec_t         vecs[$];

    div4b_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] a, b, q, r, input logic dbz, ovf);
        vec_t v;
        v = '{a, b, q, r, dbz, ovf};
        vecs.push_back(v);
    endtask

    // called at a falling edge; the op is accepted on the next rising edge
    task automatic launch(input logic [W-1:0] a, b, q, r, input logic dbz, ovf);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back({ovf, dbz, q, r});
    endtask

    // returns at the falling edge where done is seen high
    task automatic finish_op(input string name, input int elat, input bit chk_hold,
                             input logic [W-1:0] hold_q);
        int         lat = -1;
        logic [9:0] e;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check({name, "_lead_done"}, done, 1'b0);
                if (elat > 1) check({name, "_busy"}, busy, 1'b1);
                if (chk_hold) check({name, "_hold_q"}, quotient, hold_q);
            end
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        e = exp_q.pop_front();
        check({name, "_latency"}, lat, elat);
        check({name, "_q"}, quotient, e[7:4]);
        check({name, "_r"}, remainder, e[3:0]);
        check({name, "_dbz"}, div_by_zero, e[8]);
        check({name, "_ovf"}, overflow, e[9]);
    endtask

    initial begin
        int seen;

`ifdef DIV4_SIGNED_EN
        add_vec(4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0);   // -7 / 2
        add_vec(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1);   // -8 / -1
        add_vec(4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0);   // 7 / -2
        add_vec(4'hA, 4'hD, 4'h2, 4'h0, 1'b0, 1'b0);   // -6 / -3
        add_vec(4'hF, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0);   // -1 / 0
        add_vec(4'h5, 4'h3, 4'h1, 4'h2, 1'b0, 1'b0);
        add_vec(4'hB, 4'h2, 4'hE, 4'hF, 1'b0, 1'b0);   // -5 / 2
`else
        add_vec(4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 1'b0);
        add_vec(4'd15, 4'd0,  4'hF,  4'hF,  1'b1, 1'b0);
        add_vec(4'd6,  4'd3,  4'd2,  4'd0,  1'b0, 1'b0);
        add_vec(4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 1'b0);
        add_vec(4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 1'b0);
        add_vec(4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 1'b0);
        add_vec(4'd7,  4'd9,  4'd0,  4'd7,  1'b0, 1'b0);
        add_vec(4'd14, 4'd3,  4'd4,  4'd2,  1'b0, 1'b0);
        add_vec(4'd9,  4'd0,  4'hF,  4'd9,  1'b1, 1'b0);
        add_vec(4'd8,  4'd2,  4'd4,  4'd0,  1'b0, 1'b0);
        add_vec(4'd1,  4'd15, 4'd0,  4'd1,  1'b0, 1'b0);
`endif

        // reset state
        #1;
        check("reset_busy_done", {busy, done}, 2'b00);
        check("reset_q_r", {quotient, remainder}, 8'h00);
        check("reset_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            launch(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
            finish_op($sformatf("vec%0d", i), vecs[i].dbz ? 1 : LAT, 1'b0, '0);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), done, 1'b0);
            check($sformatf("vec%0d_held_q", i), quotient, vecs[i].q);
        end

`ifndef DIV4_SIGNED_EN
        // exhaustive unsigned sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                @(negedge clk);
                launch(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 1'b0);
                finish_op($sformatf("ex_%0d_%0d", a, b), LAT, 1'b0, '0);
                @(negedge clk);
                check($sformatf("ex_%0d_%0d_pulse", a, b), done, 1'b0);
            end
        end
`endif

        // start pulsed throughout the run with fresh operands is ignored
        @(negedge clk);
        start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check($sformatf("ign_busy%0d", i), busy, 1'b1);
            start    = 1'b1;
            dividend = 4'($urandom_range(0, 15));
            divisor  = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        start = 1'b0;
        check("ign_done", done, 1'b1);
        check("ign_q_r", {quotient, remainder}, {4'd3, 4'd1});
        @(negedge clk);
        check("ign_noqueue", {busy, done}, 2'b00);

        // back-to-back: start held in DONE, old results held until the new done
        @(negedge clk);
        launch(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0);
        finish_op("b2b_first", LAT, 1'b0, '0);
        launch(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0);
        finish_op("b2b_second", LAT, 1'b1, 4'd3);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy_done", {busy, done}, 2'b00);
        check("arst_q_r", {quotient, remainder}, 8'h00);
        check("arst_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_no_done", seen, 0);
        @(negedge clk);
        launch(4'd5, 4'd2, 4'd2, 4'd1, 1'b0, 1'b0);
        finish_op("post_reset", LAT, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
